// File: rtl/cv32e40s_div_arb.sv
// Two-port arbiter/sequencer sharing one cv32e40s_div between two requesters.
// Macro DIV_ARB_RR_EN: defined = round-robin priority pointer; undefined = fixed priority (port 0 wins).
package cv32e40s_div_arb_pkg;
  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_opcode_e;
endpackage

module cv32e40s_div_arb
  import cv32e40s_div_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2  // the owner/priority encoding is one bit wide
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [NREQ-1:0][31:0]      req_op_a_i,
  input  logic [NREQ-1:0][31:0]      req_op_b_i,
  input  div_opcode_e                req_operator_i [NREQ],
  input  logic [NREQ-1:0]            req_dit_i,
  output logic [NREQ-1:0]            rsp_valid_o,
  input  logic [NREQ-1:0]            rsp_ready_i,
  output logic [31:0]                rsp_result_o,
  output logic                       div_valid_o,
  input  logic                       div_ready_i,
  output logic [31:0]                div_op_a_o,
  output logic [31:0]                div_op_b_o,
  output div_opcode_e                div_operator_o,
  output logic                       div_dit_o,
  output logic                       div_en_o,
  input  logic                       div_rvalid_i,
  output logic                       div_rready_o,
  input  logic [31:0]                div_result_i,
  output logic                       busy_o,
  output logic                       owner_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_owner;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  div_opcode_e r_operator;
  logic        r_dit;

  logic w_winner;
  logic w_accept;
  logic w_rsp_done;

`ifdef DIV_ARB_RR_EN
  logic r_prio;
  assign w_winner = (&req_valid_i) ? r_prio : ~req_valid_i[0];
`else
  assign w_winner = ~req_valid_i[0];
`endif

  // Gated by rst_n so req_ready_o is low while reset is asserted even if requests are pending.
  assign w_accept   = rst_n && (r_state == S_IDLE) && (|req_valid_i);
  assign w_rsp_done = (r_state == S_WAIT) && div_rvalid_i && rsp_ready_i[r_owner];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt  = r_state;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    rsp_result_o = '0;
    div_valid_o  = 1'b0;
    div_en_o     = 1'b0;
    div_rready_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          req_ready_o[w_winner] = 1'b1;
          w_state_nxt           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_valid_o = 1'b1;
        div_en_o    = 1'b1;
        if (div_ready_i) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        div_en_o              = 1'b1;
        rsp_valid_o[r_owner]  = div_rvalid_i;
        rsp_result_o          = div_result_i;
        div_rready_o          = rsp_ready_i[r_owner];
        if (w_rsp_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the operand registers are a handful of flops, so they are reset to give clean zero outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_operator <= DIV_DIV;
      r_dit      <= 1'b0;
    end else if (w_accept) begin
      r_owner    <= w_winner;
      r_op_a     <= req_op_a_i[w_winner];
      r_op_b     <= req_op_b_i[w_winner];
      r_operator <= req_operator_i[w_winner];
      r_dit      <= req_dit_i[w_winner];
    end
  end

`ifdef DIV_ARB_RR_EN
  // The port just served loses the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_prio <= 1'b0;
    else if (w_rsp_done) r_prio <= ~r_owner;
  end
`endif

  assign div_op_a_o     = r_op_a;
  assign div_op_b_o     = r_op_b;
  assign div_operator_o = r_operator;
  assign div_dit_o      = r_dit;
  assign busy_o         = (r_state != S_IDLE);
  assign owner_o        = r_owner;

endmodule

// File: tb/tb_cv32e40s_div_arb.sv
// Self-checking bench for cv32e40s_div_arb: divider stub, transaction-level model, directed and random traffic.
module tb_cv32e40s_div_arb;
  import cv32e40s_div_arb_pkg::*;

`ifdef DIV_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid_i = '0;
  logic [1:0]       req_ready_o;
  logic [1:0][31:0] req_op_a_i = '0;
  logic [1:0][31:0] req_op_b_i = '0;
  div_opcode_e      req_operator_i [2];
  logic [1:0]       req_dit_i = '0;
  logic [1:0]       rsp_valid_o;
  logic [1:0]       rsp_ready_i = '0;
  logic [31:0]      rsp_result_o;
  logic             div_valid_o;
  logic             div_ready_i = 1'b0;
  logic [31:0]      div_op_a_o, div_op_b_o;
  div_opcode_e      div_operator_o;
  logic             div_dit_o, div_en_o;
  logic             div_rvalid_i = 1'b0;
  logic             div_rready_o;
  logic [31:0]      div_result_i = '0;
  logic             busy_o, owner_o;

  cv32e40s_div_arb #(.NREQ(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
    .req_operator_i(req_operator_i), .req_dit_i(req_dit_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .div_valid_o(div_valid_o), .div_ready_i(div_ready_i),
    .div_op_a_o(div_op_a_o), .div_op_b_o(div_op_b_o),
    .div_operator_o(div_operator_o), .div_dit_o(div_dit_o), .div_en_o(div_en_o),
    .div_rvalid_i(div_rvalid_i), .div_rready_o(div_rready_o), .div_result_i(div_result_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension divide/remainder semantics.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input div_opcode_e op);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      DIV_DIV:  begin
        if (b == 0) ref_div = 32'hFFFF_FFFF;
        else if (ovf) ref_div = a;
        else ref_div = $signed(a) / $signed(b);
      end
      DIV_DIVU: ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      DIV_REM:  begin
        if (b == 0) ref_div = a;
        else if (ovf) ref_div = 32'h0;
        else ref_div = $signed(a) % $signed(b);
      end
      default:  ref_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(5))
      0:       rand_word = 32'h8000_0000;
      1:       rand_word = 32'hFFFF_FFFF;
      2:       rand_word = 32'h0;
      3:       rand_word = $urandom_range(10);
      default: rand_word = $urandom;
    endcase
  endfunction

  // ---------------- transaction-level model and per-cycle compare ----------------
  logic        m_busy, m_issued, m_owner, m_prio, m_dit;
  logic [31:0] m_a, m_b;
  div_opcode_e m_op;
  int          n_done = 0;
  int          grant_log [$];
  logic [1:0]  hs_req = '0;
  logic        hs_div = 1'b0, hs_rsp = 1'b0;
  logic [31:0] cap_a = '0, cap_b = '0;
  div_opcode_e cap_op = DIV_DIV;

  always @(negedge clk or negedge rst_n) begin
    int         w;
    logic [1:0] exp_v;
    if (!rst_n) begin
      m_busy = 1'b0; m_issued = 1'b0; m_owner = 1'b0; m_prio = 1'b0;
      hs_req <= '0; hs_div <= 1'b0; hs_rsp <= 1'b0;
    end else begin
      if (!m_busy) begin
        w = -1;
        if (req_valid_i == 2'b11) w = RR_EN ? int'(m_prio) : 0;
        else if (req_valid_i[0])  w = 0;
        else if (req_valid_i[1])  w = 1;
        exp_v = (w < 0) ? 2'b00 : 2'(1 << w);
        check("req_ready", req_ready_o, exp_v);
        check("idle_ctl", {busy_o, div_valid_o, div_en_o, rsp_valid_o, div_rready_o}, '0);
        if (w >= 0) begin
          m_a = req_op_a_i[w]; m_b = req_op_b_i[w]; m_op = req_operator_i[w];
          m_dit = req_dit_i[w]; m_owner = w[0]; m_busy = 1'b1; m_issued = 1'b0;
          grant_log.push_back(w);
        end
      end else if (!m_issued) begin
        check("issue_ctl", {busy_o, div_valid_o, div_en_o, req_ready_o, rsp_valid_o, div_rready_o, owner_o},
              {1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, m_owner});
        check("issue_a", div_op_a_o, m_a);
        check("issue_b", div_op_b_o, m_b);
        check("issue_op_dit", {div_operator_o, div_dit_o}, {m_op, m_dit});
        if (div_ready_i) m_issued = 1'b1;
      end else begin
        exp_v = div_rvalid_i ? 2'(1 << m_owner) : 2'b00;
        check("wait_ctl",
              {busy_o, div_valid_o, div_en_o, req_ready_o, rsp_valid_o, div_rready_o, owner_o, div_dit_o},
              {1'b1, 1'b0, 1'b1, 2'b00, exp_v, rsp_ready_i[m_owner], m_owner, m_dit});
        if (div_rvalid_i) check("rsp_result", rsp_result_o, ref_div(m_a, m_b, m_op));
        if (div_rvalid_i && rsp_ready_i[m_owner]) begin
          m_busy = 1'b0; m_prio = ~m_owner; n_done++;
        end
      end
      hs_req <= req_ready_o & req_valid_i;
      hs_div <= div_valid_o & div_ready_i;
      hs_rsp <= div_rvalid_i & div_rready_o;
      cap_a  <= div_op_a_o;
      cap_b  <= div_op_b_o;
      cap_op <= div_operator_o;
    end
  end

  // ---------------- divider stub ----------------
  int          rdy_pct = 100;
  int          lat_fix = 2;
  int          d_state = 0;
  int          d_cnt = 0;
  logic [31:0] d_res = '0;

  always begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      d_state = 0; div_ready_i = 1'b0; div_rvalid_i = 1'b0; div_result_i = '0;
    end else begin
      case (d_state)
        0: begin
          if (hs_div) begin
            d_res = ref_div(cap_a, cap_b, cap_op);
            d_cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(5));
            div_ready_i = 1'b0;
            d_state = 1;
          end else begin
            div_ready_i = ($urandom_range(99) < rdy_pct);
          end
        end
        1: begin
          if (d_cnt == 0) begin
            div_rvalid_i = 1'b1; div_result_i = d_res; d_state = 2;
          end else d_cnt--;
        end
        default: begin
          if (hs_rsp) begin
            div_rvalid_i = 1'b0; div_result_i = $urandom; d_state = 0;
          end
        end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input div_opcode_e op, input logic dit);
    req_op_a_i[p] = a; req_op_b_i[p] = b; req_operator_i[p] = op;
    req_dit_i[p] = dit; req_valid_i[p] = 1'b1;
  endtask

  task automatic new_req(input int p);
    set_req(p, rand_word(), rand_word(), div_opcode_e'($urandom_range(3)), 1'($urandom_range(1)));
  endtask

  task automatic wait_rsp(input int n, input string nm);
    bit seen = 0;
    for (int i = 0; i < n && !seen; i++) begin
      if (rsp_valid_o != 0) seen = 1;
      else @(negedge clk);
    end
    check({nm, "_seen"}, seen, 1'b1);
  endtask

  task automatic drain(input string nm);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk); #1;
      req_valid_i = req_valid_i & ~hs_req;
      if (req_valid_i == 2'b00 && !busy_o) done = 1;
    end
    check({nm, "_drain"}, done, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    req_valid_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    logic [31:0] pay_a;
    int          cnt [2];
    bit          found;
    req_operator_i[0] = DIV_DIV;
    req_operator_i[1] = DIV_DIV;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {req_ready_o, rsp_valid_o, div_valid_o, div_en_o, div_rready_o, busy_o, owner_o, div_dit_o}, '0);
    check("rst_ops", {div_op_a_o, div_op_b_o}, '0);
    check("rst_res", {rsp_result_o, div_operator_o}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request: 100 / 7 DIVU on port 0
    rsp_ready_i = 2'b11; rdy_pct = 100; lat_fix = 2;
    set_req(0, 32'd100, 32'd7, DIV_DIVU, 1'b0);
    @(negedge clk);
    check("t1_ready", req_ready_o, 2'b01);
    @(posedge clk); #1;
    req_valid_i = '0;
    @(negedge clk);
    check("t1_div_valid", div_valid_o, 1'b1);
    check("t1_op_a", div_op_a_o, 32'd100);
    wait_rsp(20, "t1");
    check("t1_rsp_valid", rsp_valid_o, 2'b01);
    check("t1_result", rsp_result_o, 32'd14);
    @(negedge clk);
    check("t1_idle", busy_o, 1'b0);

    // Contention: both ports valid, 4 operations each
    do_reset();
    grant_log.delete();
    lat_fix = -1;
    cnt[0] = 0; cnt[1] = 0;
    new_req(0); new_req(1);
    for (int c = 0; c < 400 && !(cnt[0] == 4 && cnt[1] == 4 && !busy_o); c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (hs_req[p]) begin
          cnt[p]++;
          if (cnt[p] < 4) new_req(p);
          else req_valid_i[p] = 1'b0;
        end
      end
    end
    check("t2_grants", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check($sformatf("t2_grant%0d", i), grant_log[i], RR_EN ? (i % 2) : (i < 4 ? 0 : 1));

    // Result back-pressure on port 1
    lat_fix = 2; rsp_ready_i = 2'b00;
    @(posedge clk); #1;
    new_req(1);
    @(negedge clk);
    check("t3_ready", req_ready_o, 2'b10);
    @(posedge clk); #1;
    req_valid_i = '0;
    wait_rsp(40, "t3");
    held = rsp_result_o;
    for (int i = 0; i < 10; i++) begin
      check("t3_rready", div_rready_o, 1'b0);
      check("t3_stable", rsp_result_o, held);
      check("t3_rsp_valid", rsp_valid_o, 2'b10);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready_i = 2'b10;
    @(negedge clk);
    check("t3_rready_on", div_rready_o, 1'b1);
    @(negedge clk);
    check("t3_idle", busy_o, 1'b0);
    rsp_ready_i = 2'b11;

    // Divider not ready for 5 cycles while port 1 waits
    rdy_pct = 0;
    @(posedge clk); #1;
    pay_a = 32'h1234_5678;
    set_req(0, pay_a, 32'd3, DIV_REMU, 1'b0);
    @(negedge clk);
    check("t4_ready", req_ready_o, 2'b01);
    @(posedge clk); #1;
    req_valid_i[0] = 1'b0;
    new_req(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_valid", div_valid_o, 1'b1);
      check("t4_payload", div_op_a_o, pay_a);
      check("t4_no_ready", req_ready_o, 2'b00);
    end
    @(posedge clk); #1;
    rdy_pct = 100;
    drain("t4");

    // Reset while port 1 owns the divider in WAIT
    lat_fix = 30;
    new_req(1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (hs_req[1]) req_valid_i[1] = 1'b0;
      if (busy_o && owner_o && !div_valid_o) found = 1;
    end
    check("t5_in_wait", found, 1'b1);
    #2;
    rst_n = 1'b0;
    req_valid_i = 2'b11;
    #1;
    check("t5_rst_ctl", {req_ready_o, rsp_valid_o, div_valid_o, div_en_o, div_rready_o, busy_o, owner_o, div_dit_o}, '0);
    check("t5_rst_ops", {div_op_a_o, div_op_b_o, rsp_result_o}, '0);
    lat_fix = 2;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t5_first_grant", req_ready_o, 2'b01);
    drain("t5");

    // Data-independent timing pass-through on port 1
    @(posedge clk); #1;
    set_req(1, 32'h8000_0000, 32'hFFFF_FFFF, DIV_REM, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    req_valid_i = '0;
    @(negedge clk);
    check("t6_issue_dit", {div_valid_o, div_dit_o}, 2'b11);
    wait_rsp(20, "t6");
    check("t6_wait_dit", div_dit_o, 1'b1);
    check("t6_rsp_valid", rsp_valid_o, 2'b10);
    check("t6_result", rsp_result_o, 32'h0);
    drain("t6");

    // Randomized traffic
    rdy_pct = 70; lat_fix = -1;
    n_done = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (hs_req[p]) req_valid_i[p] = 1'b0;
        else if (req_valid_i[p] && $urandom_range(99) < 3) req_valid_i[p] = 1'b0;
        else if (!req_valid_i[p] && $urandom_range(99) < 40) new_req(p);
        rsp_ready_i[p] = ($urandom_range(99) < 75);
      end
    end
    rsp_ready_i = 2'b11;
    drain("rand");
    check("rand_ops", n_done > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40s_div_arb.md
# cv32e40s_div_arb

Two-port arbiter and sequencer that shares a single `cv32e40s_div` instance between two requesters, for example a primary and a secondary issue path. It captures one request's operands and opcode into registers and issues them to the divider with a valid/ready handshake. It routes the divider's result back to the owning requester and holds the grant until that result is accepted. The block sits between the requesters and the divider's `op_a_i/op_b_i/operator_i/data_ind_timing_i/valid_i/ready_o/result_o/valid_o/ready_i` pins.

## Interface
Parameters:
- NREQ, 2, number of requesters; fixed, other values unsupported.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  2  per-port request valid.
- req_ready_o  out  2  per-port request accepted this cycle.
- req_op_a_i  in  2x32  per-port dividend.
- req_op_b_i  in  2x32  per-port divisor.
- req_operator_i  in  2x div_opcode_e  per-port DIV/DIVU/REM/REMU.
- req_dit_i  in  2  per-port data-independent-timing request.
- rsp_valid_o  out  2  per-port result valid.
- rsp_ready_i  in  2  per-port result accept.
- rsp_result_o  out  32  result; meaningful only under rsp_valid_o.
- div_valid_o  out  1  to divider valid_i.
- div_ready_i  in  1  from divider ready_o.
- div_op_a_o, div_op_b_o  out  32  to divider operands.
- div_operator_o  out  div_opcode_e  to divider operator_i.
- div_dit_o  out  1  to divider data_ind_timing_i.
- div_en_o  out  1  to divider div_en_i; high in ISSUE and WAIT.
- div_rvalid_i  in  1  from divider valid_o.
- div_rready_o  out  1  to divider ready_i.
- div_result_i  in  32  from divider result_o.
- busy_o  out  1  state != IDLE.
- owner_o  out  1  index of the current grant holder.

## Operation
- States: IDLE, ISSUE, WAIT.
- Requester handshake:
  - IDLE: if any req_valid_i is set, select winner g.
  - Assert req_ready_o[g] combinationally for that cycle only; req_ready_o is 0 in all other states.
  - Capture op_a/op_b/operator/dit of port g into registers, set owner_o=g, go to ISSUE.
- Issue to divider:
  - ISSUE: div_valid_o=1, driven only from the registered values.
  - When div_ready_i=1 the handshake completes; go to WAIT.
- Result return:
  - WAIT: rsp_valid_o[owner]=div_rvalid_i and rsp_result_o=div_result_i; div_rready_o=rsp_ready_i[owner].
  - The non-owner's rsp_valid_o is always 0.
  - When div_rvalid_i and rsp_ready_i[owner] are both 1, go to IDLE and update priority.
- Arbitration: a priority pointer `prio` resets to 0. With both ports valid, port `prio` wins. After each completed result, prio = ~owner.
- Requests arriving in ISSUE or WAIT are not accepted; requesters hold valid and payload until req_ready_o.
- A requester dropping req_valid_i before acceptance is legal and has no effect.
- Operand registers are loaded only on acceptance. Divide-by-zero and overflow semantics are entirely the divider's.
- Reset, including mid-operation: state=IDLE, prio=0, owner_o=0, operand registers=0, every output=0.
  - An in-flight divider result is dropped; the divider shares rst_n and resets with the arbiter.

## Timing
- Acceptance to div_valid_o: 1 cycle.
- div_valid_o stays high, with payload stable, until div_ready_i.
- Divider result to requester: combinational pass-through; zero added cycles.
- Back-to-back: after the result handshake in cycle N, a new acceptance can occur in N+1 (IDLE) and issue in N+2. Throughput bound is divider latency + 2 cycles per operation.
- Simultaneous requests in IDLE: exactly one req_ready_o bit is set; the loser waits for at least one full operation.
- Result stall: rsp_ready_i[owner]=0 holds WAIT indefinitely, with div_rready_o=0 back-pressuring the divider.

## Configuration
- Macro DIV_ARB_RR_EN.
- Defined: round-robin arbitration via `prio` as described.
- Undefined: fixed priority; port 0 always wins simultaneous requests, `prio` is not implemented, and port 1 can starve.

## Test plan
- Single request: port 0 with 100 / 7 DIVU, divider ready immediately → req_ready_o=01 in cycle 0, div_valid_o in cycle 1, rsp_valid_o=01 with rsp_result_o=14, then busy_o=0.
- Contention with DIV_ARB_RR_EN: both ports valid continuously with 4 ops each → grants alternate 0,1,0,1…; without the macro, all grants go to port 0 while it stays valid.
- Back-pressure: hold rsp_ready_i[owner]=0 for 10 cycles after div_rvalid_i → div_rready_o=0 and rsp_result_o stable throughout; completion occurs on the first cycle rsp_ready_i=1.
- Divider not ready: div_ready_i=0 for 5 cycles in ISSUE → div_valid_o stays 1 with an unchanged payload, and no second req_ready_o occurs.
- Reset mid-WAIT: assert rst_n=0 while owner=1 → all outputs 0 asynchronously, and after release the first request is granted to port 0.
- DIT pass-through: port 1 with req_dit_i=1, REM 0x80000000 / 0xFFFFFFFF → div_dit_o=1 during ISSUE/WAIT and rsp_result_o=0 on port 1.
